// File: rtl/seg_scan6.sv
// seg_scan6: six-digit multiplexed seven-segment driver for the stopwatch.
// Digits are snapshotted once per scan frame so a frame never mixes two counter
// values. Anodes, segments and the decimal point are active-low and registered.
module seg_scan6 #(
   parameter int SCAN_DIV = 50000,  // clocks per digit slot (>= 2)
   parameter int BLANK    = 16      // anode-off cycles at start of each slot (< SCAN_DIV)
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [3:0] ms_d,
   input  logic [3:0] ms_g,
   input  logic [3:0] second_d,
   input  logic [3:0] second_g,
   input  logic [3:0] minute_d,
   input  logic [3:0] minute_g,
   input  logic       blank_lz,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [DW-1:0]   div_q, div_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0][3:0] snap_q, snap_d;
   logic            load_pending_q;
   logic [5:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            ft_q, ft_d;

   logic            wrap, load, active, lz_blank;
   logic [3:0]      cur;

   // Active-low decode; 10..15 show a dash (segment g only).
   function automatic logic [6:0] dec7(input logic [3:0] v);
      case (v)
         4'd0:    dec7 = 7'h40;
         4'd1:    dec7 = 7'h79;
         4'd2:    dec7 = 7'h24;
         4'd3:    dec7 = 7'h30;
         4'd4:    dec7 = 7'h19;
         4'd5:    dec7 = 7'h12;
         4'd6:    dec7 = 7'h02;
         4'd7:    dec7 = 7'h78;
         4'd8:    dec7 = 7'h00;
         4'd9:    dec7 = 7'h10;
         default: dec7 = 7'h3F;
      endcase
   endfunction

   // Next-state: divider/slot advance, snapshot load, and output decode of the
   // pre-edge state (outputs lag the scan state by one cycle).
   always_comb begin
      wrap   = (div_q == DW'(SCAN_DIV - 1));
      load   = load_pending_q || (wrap && (idx_q == 3'd5));
      div_d  = wrap ? '0 : div_q + 1'b1;
      idx_d  = idx_q;
      if (wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      snap_d = load ? {minute_g, minute_d, second_g, second_d, ms_g, ms_d} : snap_q;

      case (idx_q)
         3'd0:    cur = snap_q[0];
         3'd1:    cur = snap_q[1];
         3'd2:    cur = snap_q[2];
         3'd3:    cur = snap_q[3];
         3'd4:    cur = snap_q[4];
         3'd5:    cur = snap_q[5];
         default: cur = 4'd0;
      endcase

      // blank_lz is taken live; only the digit value comes from the snapshot
      lz_blank = (idx_q == 3'd5) && blank_lz && (snap_q[5] == 4'd0);
      active   = (div_q >= DW'(BLANK)) && !lz_blank;
      an_d     = active ? ~(6'b000001 << idx_q) : 6'h3F;
      seg_d    = dec7(cur);
      dp_d     = !(active && ((idx_q == 3'd2) || (idx_q == 3'd4)));
      ft_d     = load;
   end

   // State and output registers; reset returns everything immediately.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         div_q          <= '0;
         idx_q          <= 3'd0;
         snap_q         <= '0;
         load_pending_q <= 1'b1;
         an_q           <= 6'h3F;
         seg_q          <= 7'h7F;
         dp_q           <= 1'b1;
         ft_q           <= 1'b0;
      end else begin
         div_q          <= div_d;
         idx_q          <= idx_d;
         snap_q         <= snap_d;
         load_pending_q <= 1'b0;
         an_q           <= an_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         ft_q           <= ft_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan6.sv
// Directed bench for seg_scan6 with SCAN_DIV=8, BLANK=2.
// k counts clock edges since reset release; after edge k the outputs show
// div=(k-1)%8, slot=((k-1)/8)%6. Snapshot reloads on edges 1, 48, 96, ...
module tb_seg_scan6;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] ms_d, ms_g, second_d, second_g, minute_d, minute_g;
   logic       blank_lz;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp, frame_tick;

   int n_chk = 0;
   int n_err = 0;
   int k = 0;

   seg_scan6 #(.SCAN_DIV(8), .BLANK(2)) dut (
      .CLK(CLK), .reset(reset),
      .ms_d(ms_d), .ms_g(ms_g), .second_d(second_d), .second_g(second_g),
      .minute_d(minute_d), .minute_g(minute_g), .blank_lz(blank_lz),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (k=%0d): got %h expected %h", tag, k, got, exp);
      end
   endtask

   // advance to edge number 'target', sampling 1 time unit after the edge
   task automatic step_to(input int target);
      while (k < target) begin
         @(posedge CLK);
         #1;
         k++;
      end
   endtask

   initial begin
      ms_d = 4'd3; ms_g = 4'd4; second_d = 4'd5; second_g = 4'd2;
      minute_d = 4'd7; minute_g = 4'd1; blank_lz = 1'b0;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_ft", 32'(frame_tick), 32'd0);
      reset = 1'b0;

      // first edge: snapshot load, outputs still from reset state (div=0)
      step_to(1);
      chk("ft_first", 32'(frame_tick), 32'd1);
      chk("an_k1", 32'(an), 32'h3F);
      step_to(2);
      chk("ft_k2", 32'(frame_tick), 32'd0);
      chk("an_blank_k2", 32'(an), 32'h3F);
      chk("seg_k2", 32'(seg), 32'h30);
      for (int i = 3; i <= 8; i++) begin
         step_to(i);
         chk("an_slot0", 32'(an), 32'b111110);
         chk("seg_slot0", 32'(seg), 32'h30);
         chk("dp_slot0", 32'(dp), 32'd1);
      end

      // slot 2: seconds units = 5, dp on once anode active
      step_to(17);
      chk("an_s2_blank", 32'(an), 32'h3F);
      chk("dp_s2_blank", 32'(dp), 32'd1);
      step_to(19);
      chk("an_s2", 32'(an), 32'b111011);
      chk("seg_s2", 32'(seg), 32'h12);
      chk("dp_s2", 32'(dp), 32'd0);

      // slot 3: seconds tens = 2, no dp; change ms_d mid-frame
      step_to(27);
      chk("an_s3", 32'(an), 32'b110111);
      chk("seg_s3", 32'(seg), 32'h24);
      chk("dp_s3", 32'(dp), 32'd1);
      ms_d = 4'd9;

      step_to(35);
      chk("an_s4", 32'(an), 32'b101111);
      chk("seg_s4", 32'(seg), 32'h78);
      chk("dp_s4", 32'(dp), 32'd0);

      step_to(43);
      chk("an_s5", 32'(an), 32'b011111);
      chk("seg_s5", 32'(seg), 32'h79);

      step_to(47);
      chk("ft_k47", 32'(frame_tick), 32'd0);
      step_to(48);
      chk("ft_k48", 32'(frame_tick), 32'd1);
      step_to(49);
      chk("ft_k49", 32'(frame_tick), 32'd0);
      chk("seg_f2_blank", 32'(seg), 32'h10);
      step_to(51);
      chk("an_f2_s0", 32'(an), 32'b111110);
      chk("seg_f2_s0", 32'(seg), 32'h10);

      // stage next frame: minute_g=0 with blanking, seconds units = 0xC
      minute_g = 4'd0;
      second_d = 4'hC;
      blank_lz = 1'b1;
      step_to(95);
      chk("ft_k95", 32'(frame_tick), 32'd0);
      step_to(96);
      chk("ft_k96", 32'(frame_tick), 32'd1);

      step_to(115);
      chk("an_dash", 32'(an), 32'b111011);
      chk("seg_dash", 32'(seg), 32'h3F);

      for (int i = 137; i <= 144; i++) begin
         step_to(i);
         chk("an_lz_blank", 32'(an), 32'h3F);
         chk("dp_lz_blank", 32'(dp), 32'd1);
      end

      blank_lz = 1'b0;
      step_to(187);
      chk("an_lz_off", 32'(an), 32'b011111);
      chk("seg_lz_off", 32'(seg), 32'h40);

      // reset mid slot 3 of the next frame
      step_to(220);
      chk("an_pre_rst", 32'(an), 32'b110111);
      reset = 1'b1;
      #1;
      chk("mid_rst_an", 32'(an), 32'h3F);
      chk("mid_rst_seg", 32'(seg), 32'h7F);
      chk("mid_rst_dp", 32'(dp), 32'd1);
      chk("mid_rst_ft", 32'(frame_tick), 32'd0);
      ms_d = 4'd6;
      @(posedge CLK);
      #1;
      reset = 1'b0;
      k = 0;
      step_to(1);
      chk("ft_rerelease", 32'(frame_tick), 32'd1);
      step_to(3);
      chk("an_after_rst", 32'(an), 32'b111110);
      chk("seg_after_rst", 32'(seg), 32'h02);
      step_to(11);
      chk("an_after_rst_s1", 32'(an), 32'b111101);
      chk("seg_after_rst_s1", 32'(seg), 32'h19);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
